// File: rtl/adder32.sv
// Two-level carry-lookahead adder: combinational sum/carry/overflow plus a
// registered copy of the same results with synchronous clear and load enable.
module adder32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             En,
  output logic [WIDTH-1:0] OUT,
  output logic             Cout,
  output logic             Ovf,
  output logic [WIDTH-1:0] OUT_R,
  output logic             Cout_R,
  output logic             Ovf_R
);

  // WIDTH must be a multiple of 4; each group covers one nibble.
  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] bit_g;
  logic [WIDTH-1:0] bit_p;
  logic [WIDTH-1:0] bit_c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;

  assign bit_g = A & B;
  assign bit_p = A ^ B;

  // First level: carries inside each nibble come straight from the group carry-in.
  for (genvar gi = 0; gi < NG; gi++) begin : g_group
    localparam int B0 = 4 * gi;
    logic [3:0] g;
    logic [3:0] p;
    logic       ci;

    assign g  = bit_g[B0 +: 4];
    assign p  = bit_p[B0 +: 4];
    assign ci = grp_c[gi];

    assign bit_c[B0]     = ci;
    assign bit_c[B0 + 1] = g[0] | (p[0] & ci);
    assign bit_c[B0 + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign bit_c[B0 + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                         | (p[2] & p[1] & p[0] & ci);

    assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p[gi] = &p;
  end

  // Second level: each group carry-in is a flat sum-of-products over the lower
  // groups' (G, P) pairs and Cin, so no carry passes through an earlier group.
  always_comb begin
    logic acc;
    logic prop;
    grp_c    = '0;
    acc      = 1'b0;
    prop     = 1'b0;
    grp_c[0] = Cin;
    for (int j = 1; j <= NG; j++) begin
      acc = 1'b0;
      for (int k = 0; k < j; k++) begin
        prop = 1'b1;
        for (int m = k + 1; m < j; m++) begin
          prop = prop & grp_p[m];
        end
        acc = acc | (grp_g[k] & prop);
      end
      prop = Cin;
      for (int m = 0; m < j; m++) begin
        prop = prop & grp_p[m];
      end
      grp_c[j] = acc | prop;
    end
  end

  assign OUT  = bit_p ^ bit_c;
  assign Cout = grp_c[NG];
  assign Ovf  = bit_c[WIDTH-1] ^ grp_c[NG];

  logic [WIDTH-1:0] out_d,  out_q;
  logic             cout_d, cout_q;
  logic             ovf_d,  ovf_q;

  always_comb begin
    out_d  = out_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (RST) begin
      out_d  = '0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (En) begin
      out_d  = OUT;
      cout_d = Cout;
      ovf_d  = Ovf;
    end
  end

  always_ff @(posedge CLK) begin
    out_q  <= out_d;
    cout_q <= cout_d;
    ovf_q  <= ovf_d;
  end

  assign OUT_R  = out_q;
  assign Cout_R = cout_q;
  assign Ovf_R  = ovf_q;

endmodule

// File: tb/tb_adder32.sv
// Scoreboard bench for adder32: directed fetch/wrap/overflow/group-carry vectors,
// random combinational vectors, and registered-path sequences.
module tb_adder32;

  logic        CLK = 1'b0;
  logic        RST, Cin, En;
  logic [31:0] A, B;
  logic [31:0] OUT, OUT_R;
  logic        Cout, Ovf, Cout_R, Ovf_R;

  adder32 #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .Cin(Cin), .En(En),
    .OUT(OUT), .Cout(Cout), .Ovf(Ovf),
    .OUT_R(OUT_R), .Cout_R(Cout_R), .Ovf_R(Ovf_R)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t reg_model;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin);
    exp_t        m;
    logic [32:0] full;
    full   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    m.out  = full[31:0];
    m.cout = full[32];
    m.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
    return m;
  endfunction

  task automatic drive_comb(input logic [31:0] a, input logic [31:0] b, input logic cin);
    A = a; B = b; Cin = cin;
    #1;
  endtask

  task automatic reg_step(input logic rst, input logic en, input logic [31:0] a,
                          input logic [31:0] b, input logic cin);
    @(negedge CLK);
    RST = rst; En = en; A = a; B = b; Cin = cin;
    if (rst)     reg_model = '0;
    else if (en) reg_model = model(a, b, cin);
  endtask

  task automatic test_reset();
    exp_t e;
    sb.push_back('0);
    @(posedge CLK); #1;
    e = sb.pop_front();
    checks++;
    if ({OUT_R, Cout_R, Ovf_R} !== {e.out, e.cout, e.ovf}) begin
      errors++;
      $display("FAIL reset regs got %h/%b/%b exp %h/%b/%b", OUT_R, Cout_R, Ovf_R, e.out, e.cout, e.ovf);
    end
    reg_model = '0;
  endtask

  task automatic test_fetch();
    logic [31:0] av[4] = '{32'h0, 32'h4, 32'h8, 32'h3FC};
    logic [31:0] ov[4] = '{32'h4, 32'h8, 32'hC, 32'h400};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({ov[i], 1'b0, 1'b0});
      drive_comb(av[i], 32'h4, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({OUT, Cout, Ovf} !== {e.out, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL fetch[%0d] got %h/%b/%b exp %h/%b/%b", i, OUT, Cout, Ovf, e.out, e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_wrap_overflow();
    logic [31:0] av[4] = '{32'hFFFFFFFC, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] bv[4] = '{32'h4, 32'h0, 32'h1, 32'h80000000};
    logic        cv[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ov[4] = '{32'h0, 32'h0, 32'h80000000, 32'h0};
    logic        co[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        vo[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({ov[i], co[i], vo[i]});
      drive_comb(av[i], bv[i], cv[i]);
      e = sb.pop_front();
      checks++;
      if ({OUT, Cout, Ovf} !== {e.out, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL wrap_ovf[%0d] got %h/%b/%b exp %h/%b/%b", i, OUT, Cout, Ovf, e.out, e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_group_carry();
    logic [31:0] one = 32'h1;
    logic [31:0] pw;
    exp_t e;
    for (int k = 1; k < 8; k++) begin
      pw = one << (4 * k);
      sb.push_back({pw, 1'b0, 1'b0});
      drive_comb(pw - 32'h1, 32'h1, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({OUT, Cout, Ovf} !== {e.out, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL group_carry[%0d] got %h/%b/%b exp %h/%b/%b", k, OUT, Cout, Ovf, e.out, e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        cin;
    exp_t        e;
    for (int i = 0; i < 10000; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      if (i % 8 == 0) a = {a[31], {31{a[30]}}};
      sb.push_back(model(a, b, cin));
      drive_comb(a, b, cin);
      e = sb.pop_front();
      checks++;
      if ({OUT, Cout, Ovf} !== {e.out, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b got %h/%b/%b exp %h/%b/%b",
                 i, a, b, cin, OUT, Cout, Ovf, e.out, e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_registered();
    logic        rv[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        ev[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] av[7] = '{32'h0, 32'h5, 32'h1, 32'h1, 32'h1, 32'h7FFFFFFF, 32'h9};
    logic [31:0] bv[7] = '{32'h0, 32'h7, 32'h0, 32'h0, 32'h0, 32'h1, 32'h9};
    logic [31:0] ov[7] = '{32'h0, 32'hC, 32'hC, 32'hC, 32'hC, 32'h80000000, 32'h0};
    logic        vo[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      reg_step(rv[i], ev[i], av[i], bv[i], 1'b0);
      sb.push_back({ov[i], 1'b0, vo[i]});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({OUT_R, Cout_R, Ovf_R} !== {e.out, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL registered[%0d] got %h/%b/%b exp %h/%b/%b", i, OUT_R, Cout_R, Ovf_R, e.out, e.cout, e.ovf);
      end
      if (rv[i]) begin
        checks++;
        if (OUT !== av[i] + bv[i]) begin
          errors++;
          $display("FAIL comb_during_reset got %h exp %h", OUT, av[i] + bv[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        rst, en, cin;
    exp_t        e;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      en  = (i < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      reg_step(rst, en, a, b, cin);
      sb.push_back(reg_model);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({OUT_R, Cout_R, Ovf_R} !== {e.out, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL back_to_back[%0d] rst=%b en=%b got %h/%b/%b exp %h/%b/%b",
                 i, rst, en, OUT_R, Cout_R, Ovf_R, e.out, e.cout, e.ovf);
      end
    end
  endtask

  initial begin
    RST = 1'b1; En = 1'b0; A = '0; B = '0; Cin = 1'b0;
    reg_model = '0;
    test_reset();
    @(negedge CLK);
    RST = 1'b0;
    test_fetch();
    test_wrap_overflow();
    test_group_carry();
    test_random();
    test_registered();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
